// File: rtl/wishbone_uart_pkg.sv
// Shared register map and STATUS layout for the wishbone UART TX FIFO slave.
package wishbone_uart_pkg;

  localparam logic [1:0] TXDATA_REG = 2'd0;
  localparam logic [1:0] STATUS_REG = 2'd1;

  localparam int unsigned EMPTY_BIT = 0;
  localparam int unsigned FULL_BIT  = 1;
  localparam int unsigned OVF_BIT   = 2;
  localparam int unsigned LEVEL_LSB = 8;
  localparam int unsigned THR_LSB   = 20;

  localparam int unsigned LEVEL_W = 9;
  localparam int unsigned THR_W   = 5;

  // Assemble the STATUS read word; unused bits stay zero.
  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic ovf,
                                              input logic [LEVEL_W-1:0] level,
                                              input logic [THR_W-1:0] thr);
    logic [31:0] w;
    w = '0;
    w[EMPTY_BIT] = empty;
    w[FULL_BIT]  = full;
    w[OVF_BIT]   = ovf;
    w[LEVEL_LSB +: LEVEL_W] = level;
    w[THR_LSB +: THR_W]     = thr;
    return w;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Show-ahead byte FIFO; accepts a push while full when a pop happens on the same edge.
module sync_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [7:0]                     din,
  output logic [7:0]                     dout,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(FIFO_DEPTH):0]    level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;
  logic [LVL_W-1:0] level_nxt;

  assign rd_en     = pop & ~empty;
  assign wr_en     = push & (~full | rd_en);
  assign level_nxt = level + LVL_W'(wr_en) - LVL_W'(rd_en);
  assign dout      = mem[rd_ptr];

  // Storage, pointers and registered flags; contents cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
    end
  end

endmodule

// File: rtl/wishbone_uart_tx_fifo_slave.sv
// Wishbone classic slave buffering TX bytes for uart_tx; STATUS register for polling.
// Optional TX_FIFO_IRQ_EN adds irq_o with a programmable level threshold.
module wishbone_uart_tx_fifo_slave
  import wishbone_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_LSB   = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_data_valid_o,
  input  logic        tx_data_ready_i
`ifdef TX_FIFO_IRQ_EN
  , output logic      irq_o
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             acc;
  logic [1:0]       reg_idx;
  logic             push;
  logic             pop;
  logic             st_wr;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             ovf_q;
  logic             ovf_nxt;
  logic [THR_W-1:0] thr;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign acc     = cyc_i & stb_i & ~ack_o;
  assign reg_idx = addr_i[ADDR_LSB+1:ADDR_LSB];
  assign push    = acc & we_i & (reg_idx == TXDATA_REG);
  assign st_wr   = acc & we_i & (reg_idx == STATUS_REG);
  assign pop     = tx_data_valid_o & tx_data_ready_i;
  assign tx_data_valid_o = ~empty;
  assign unused_bits = ^{addr_i, data_i};

  sync_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (push),
    .pop   (pop),
    .din   (data_i[7:0]),
    .dout  (tx_data_o),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_comb begin
    ovf_nxt = ovf_q;
    if (st_wr && data_i[OVF_BIT]) ovf_nxt = 1'b0;
    if (push && full && !pop)     ovf_nxt = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (reg_idx == STATUS_REG)
      rdata = status_word(empty, full, ovf_q, LEVEL_W'(level), thr);
  end

  // Single-cycle ack; read data only present alongside a read ack.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_o  <= 1'b0;
      data_o <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ack_o  <= acc;
      data_o <= (acc && !we_i) ? rdata : '0;
      ovf_q  <= ovf_nxt;
    end
  end

`ifdef TX_FIFO_IRQ_EN
  logic [THR_W-1:0] thr_q;
  assign thr = thr_q;

  // Level-sensitive interrupt, one cycle behind the FIFO level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      thr_q <= '0;
      irq_o <= 1'b0;
    end else begin
      if (st_wr) thr_q <= data_i[THR_LSB +: THR_W];
      irq_o <= (LEVEL_W'(level) <= LEVEL_W'(thr_q));
    end
  end
`else
  assign thr = '0;
`endif

endmodule

// File: tb/tb_wishbone_uart_tx_fifo_slave.sv
// Scoreboard bench: stimulus queues expected bus read data and TX bytes; a monitor checks them.
module tb_wishbone_uart_tx_fifo_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] data_o;
  logic        ack_o;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
`ifdef TX_FIFO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_bus[$];
  logic [7:0]  exp_tx[$];

  always #5 clk = ~clk;

  wishbone_uart_tx_fifo_slave #(.FIFO_DEPTH(16), .ADDR_LSB(2)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .addr_i          (addr),
    .we_i            (we),
    .data_i          (wdata),
    .cyc_i           (cyc),
    .stb_i           (stb),
    .data_o          (data_o),
    .ack_o           (ack_o),
    .tx_data_o       (tx_data),
    .tx_data_valid_o (tx_valid),
    .tx_data_ready_i (tx_ready)
`ifdef TX_FIFO_IRQ_EN
    , .irq_o         (irq)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every ack and every accepted TX byte against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_o) begin
        if (exp_bus.size() == 0) check("bus_unexpected_ack", 32'd1, 32'd0);
        else check("bus_rdata", data_o, exp_bus.pop_front());
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) check("tx_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  // One bus access from posedge+1; optionally pulse tx_ready on the ack edge.
  task automatic wb(input logic [1:0] idx, input logic w, input logic [31:0] d,
                    input logic [31:0] exp_rd, input bit with_pop);
    addr = 32'(idx) << 2;
    we = w; wdata = d; cyc = 1'b1; stb = 1'b1;
    if (with_pop) tx_ready = 1'b1;
    exp_bus.push_back(exp_rd);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("ack_rise", 32'(ack_o), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_single", 32'(ack_o), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit keep);
    if (keep) exp_tx.push_back(b);
    wb(2'd0, 1'b1, 32'(b), 32'd0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1'b1;
    while (tx_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b0;
    check("drain_done", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);

    // Held strobe over four edges: acked on the 1st and 3rd.
    addr = 32'h4; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    exp_bus.push_back(32'h1); exp_bus.push_back(32'h1);
    repeat (4) @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Three bytes buffered, then drained in order.
    push_byte(8'h41, 1); push_byte(8'h42, 1); push_byte(8'h43, 1);
    wb(2'd1, 1'b0, 32'd0, 32'h0000_0300, 1'b0);
    check("head_byte", 32'(tx_data), 32'h41);
    check("valid_when_nonempty", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_ready = 1'b0;
    wb(2'd1, 1'b0, 32'd0, 32'h0000_0001, 1'b0);
    wb(2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    wb(2'd0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Overflow: 17th byte dropped, then cleared.
    for (int i = 0; i < 17; i++) push_byte(8'(8'h60 + i), i < 16);
    wb(2'd1, 1'b0, 32'd0, 32'h0000_1006, 1'b0);
    wb(2'd1, 1'b1, 32'h4, 32'd0, 1'b0);
    wb(2'd1, 1'b0, 32'd0, 32'h0000_1002, 1'b0);

    // Push while full together with a pop: accepted, no overflow.
    exp_tx.push_back(8'h55);
    wb(2'd0, 1'b1, 32'h55, 32'd0, 1'b1);
    wb(2'd1, 1'b0, 32'd0, 32'h0000_1002, 1'b0);
    drain();
    wb(2'd1, 1'b0, 32'd0, 32'h0000_0001, 1'b0);

    // Reset mid-drain at level 5.
    for (int i = 0; i < 7; i++) push_byte(8'(8'h30 + i), 1);
    tx_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    tx_ready = 1'b0;
    #1 check("rst_valid_async", 32'(tx_valid), 32'd0);
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", 32'(ack_o), 32'd0);
    wb(2'd1, 1'b0, 32'd0, 32'h0000_0001, 1'b0);

`ifdef TX_FIFO_IRQ_EN
    wb(2'd1, 1'b1, 32'h0020_0000, 32'd0, 1'b0);
    wb(2'd1, 1'b0, 32'd0, 32'h0020_0001, 1'b0);
    check("irq_empty", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i), 1);
    check("irq_lvl4", 32'(irq), 32'd0);
    tx_ready = 1'b1; @(posedge clk); #1 tx_ready = 1'b0;
    @(posedge clk); #1;
    check("irq_lvl3", 32'(irq), 32'd0);
    tx_ready = 1'b1; @(posedge clk); #1 tx_ready = 1'b0;
    check("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_rise", 32'(irq), 32'd1);
    push_byte(8'hA4, 1);
    check("irq_fall", 32'(irq), 32'd0);
    drain();
    wb(2'd1, 1'b0, 32'd0, 32'h0020_0001, 1'b0);
`endif

    repeat (2) @(posedge clk); #1;
    check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
